// File: rtl/riscv_pkg.sv
// Shared core types: register address/data widths and the writeback entry
// carried between the writeback stage and the register file.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   typedef logic [AW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0] xlen_t;

   typedef struct packed {
      reg_addr_t addr;
      xlen_t     data;
   } wb_entry_t;

   localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/regfile_write_queue_chk.sv
// Protocol checker for the writeback queue, observing only its ports.
module regfile_write_queue_chk
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   input logic                   enq_valid,
   input logic                   enq_ready,
   input logic                   reg_write_enable,
   input logic [AW-1:0]          write_addr,
   input logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   // Sampled at each edge outside reset
   always @(posedge clk) begin
      if (!rst) begin
         a_no_enq_full: assert (!(enq_valid && enq_ready && (count == CW'(DEPTH))));
         a_count_max:   assert (count <= CW'(DEPTH));
         a_no_x0_write: assert (!(reg_write_enable && (write_addr == '0)));
      end
   end

endmodule

// File: rtl/regfile_write_queue_fwd.sv
// Youngest-match search over the pending writeback entries, walking from the
// head (oldest) towards the tail so the last match found is the youngest.
module regfile_write_queue_fwd
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = PW + 1
) (
   input  logic [DEPTH*WB_ENTRY_W-1:0] entries_i,
   input  logic [PW-1:0]               rd_ptr_i,
   input  logic [CW-1:0]               count_i,
   input  logic [AW-1:0]               addr_i,
   output logic                        hit_o,
   output logic [XLEN-1:0]             data_o
);

   wb_entry_t [DEPTH-1:0] ent_s;
   logic [PW-1:0]         idx_s;
   logic                  match_s;

   assign ent_s = entries_i;

   // Scan occupied slots oldest-first; later matches override earlier ones
   always_comb begin
      hit_o   = 1'b0;
      data_o  = '0;
      idx_s   = '0;
      match_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         idx_s   = rd_ptr_i + PW'(i);
         match_s = (CW'(i) < count_i) && (ent_s[idx_s].addr == addr_i) && (addr_i != '0);
         hit_o   = hit_o | match_s;
         data_o  = match_s ? ent_s[idx_s].data : data_o;
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// Writeback queue in front of the 32x32 register file: FIFO buffering, a
// one-cycle registered write pulse per drained entry, and two forwarding ports.
module regfile_write_queue
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enq_valid,
   output logic                   enq_ready,
   input  logic [AW-1:0]          enq_addr,
   input  logic [XLEN-1:0]        enq_data,
   input  logic                   wb_stall,
   output logic                   reg_write_enable,
   output logic [AW-1:0]          write_addr,
   output logic [XLEN-1:0]        write_data,
   input  logic [AW-1:0]          lookup_addr1,
   input  logic [AW-1:0]          lookup_addr2,
   output logic                   fwd_hit1,
   output logic                   fwd_hit2,
   output logic [XLEN-1:0]        fwd_data1,
   output logic [XLEN-1:0]        fwd_data2,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  wen_q, wen_d;
   reg_addr_t             waddr_q, waddr_d;
   xlen_t                 wdata_q, wdata_d;

   logic                  full_s, push_s, pop_s;
   logic                  qhit1_s, qhit2_s, ohit1_s, ohit2_s;
   xlen_t                 qdata1_s, qdata2_s;

   assign full_s    = (count_q == CW'(DEPTH));
   assign enq_ready = ~full_s;
   // x0 writes complete the handshake but are dropped
   assign push_s    = enq_valid && ~full_s && (enq_addr != '0);
   assign pop_s     = ~wb_stall && (count_q != '0);

   // Next-state for storage, pointers, occupancy and the output stage
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = '{addr: enq_addr, data: enq_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         wen_d    = 1'b1;
         waddr_d  = mem_q[rd_ptr_q].addr;
         wdata_d  = mem_q[rd_ptr_q].data;
      end else begin
         rd_ptr_d = rd_ptr_q;
         wen_d    = 1'b0;
         waddr_d  = waddr_q;
         wdata_d  = wdata_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   regfile_write_queue_fwd #(.DEPTH(DEPTH)) u_fwd1 (
      .entries_i (mem_q),
      .rd_ptr_i  (rd_ptr_q),
      .count_i   (count_q),
      .addr_i    (lookup_addr1),
      .hit_o     (qhit1_s),
      .data_o    (qdata1_s)
   );

   regfile_write_queue_fwd #(.DEPTH(DEPTH)) u_fwd2 (
      .entries_i (mem_q),
      .rd_ptr_i  (rd_ptr_q),
      .count_i   (count_q),
      .addr_i    (lookup_addr2),
      .hit_o     (qhit2_s),
      .data_o    (qdata2_s)
   );

   // The output stage is older than every queued entry, so it only answers on a queue miss
   assign ohit1_s   = wen_q && (waddr_q == lookup_addr1) && (lookup_addr1 != '0);
   assign ohit2_s   = wen_q && (waddr_q == lookup_addr2) && (lookup_addr2 != '0);
   assign fwd_hit1  = qhit1_s | ohit1_s;
   assign fwd_hit2  = qhit2_s | ohit2_s;
   assign fwd_data1 = qhit1_s ? qdata1_s : (ohit1_s ? wdata_q : '0);
   assign fwd_data2 = qhit2_s ? qdata2_s : (ohit2_s ? wdata_q : '0);

   assign reg_write_enable = wen_q;
   assign write_addr       = waddr_q;
   assign write_data       = wdata_q;
   assign count            = count_q;
   assign empty            = (count_q == '0);

endmodule

// File: tb/tb_regfile_write_queue.sv
// Randomized and directed bench for regfile_write_queue against a queue-based reference model.
module tb_regfile_write_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        enq_valid;
   logic        enq_ready;
   logic [4:0]  enq_addr;
   logic [31:0] enq_data;
   logic        wb_stall;
   logic        reg_write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [4:0]  lookup_addr1, lookup_addr2;
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
   logic [2:0]  count;
   logic        empty;

   regfile_write_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_addr(enq_addr), .enq_data(enq_data), .wb_stall(wb_stall),
      .reg_write_enable(reg_write_enable), .write_addr(write_addr), .write_data(write_data),
      .lookup_addr1(lookup_addr1), .lookup_addr2(lookup_addr2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .count(count), .empty(empty)
   );

   regfile_write_queue_chk #(.DEPTH(DEPTH)) u_chk (
      .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
      .reg_write_enable(reg_write_enable), .write_addr(write_addr), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file fed by the DUT write port
   logic [31:0] rf_dut [32];
   always @(posedge clk) begin
      if (reg_write_enable === 1'b1) rf_dut[write_addr] <= write_data;
   end

   typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
   ent_t        mq[$];
   logic        mo_wen;
   logic [4:0]  mo_a;
   logic [31:0] mo_d;
   logic [31:0] rf_m [32];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      else n_pass++;
   endtask

   function automatic void fwd_ref(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = 32'd0;
      if (a != 5'd0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == a) begin
               h = 1'b1;
               d = mq[i].d;
               break;
            end
         end
         if (!h && mo_wen && (mo_a == a)) begin
            h = 1'b1;
            d = mo_d;
         end
      end
   endfunction

   task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic st);
      enq_valid = v;
      enq_addr  = a;
      enq_data  = d;
      wb_stall  = st;
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs
   task automatic cycle();
      logic        h;
      logic [31:0] d;
      logic        accept, pop;
      ent_t        e;
      #1;
      check("enq_ready", enq_ready, mq.size() < DEPTH);
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      fwd_ref(lookup_addr1, h, d);
      check("fwd_hit1", fwd_hit1, h);
      check("fwd_data1", fwd_data1, d);
      fwd_ref(lookup_addr2, h, d);
      check("fwd_hit2", fwd_hit2, h);
      check("fwd_data2", fwd_data2, d);
      accept = enq_valid && (mq.size() < DEPTH);
      pop    = !wb_stall && (mq.size() > 0);
      if (mo_wen) rf_m[mo_a] = mo_d;
      if (rst) begin
         mq.delete();
         mo_wen = 1'b0;
         mo_a   = 5'd0;
         mo_d   = 32'd0;
      end else begin
         if (pop) begin
            e      = mq.pop_front();
            mo_wen = 1'b1;
            mo_a   = e.a;
            mo_d   = e.d;
         end else begin
            mo_wen = 1'b0;
         end
         if (accept && (enq_addr != 5'd0)) mq.push_back('{a: enq_addr, d: enq_data});
      end
      @(posedge clk);
      #1;
      check("wen", reg_write_enable, mo_wen);
      check("waddr", write_addr, mo_a);
      check("wdata", write_data, mo_d);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_dut[i] = 32'd0;
         rf_m[i]   = 32'd0;
      end
      mo_wen = 1'b0; mo_a = 5'd0; mo_d = 32'd0;
      rst = 1'b1;
      lookup_addr1 = 5'd0; lookup_addr2 = 5'd0;
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_wen", reg_write_enable, 1'b0);
      check("rst_waddr", write_addr, 5'd0);
      check("rst_wdata", write_data, 32'd0);
      check("rst_count", count, 3'd0);
      check("rst_empty", empty, 1'b1);
      rst = 1'b0;

      // 1: single write, one-cycle pulse then commit
      drive(1'b1, 5'd1, 32'hDEADBEEF, 1'b0);
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      cycle();
      check("t1_wen", reg_write_enable, 1'b1);
      check("t1_waddr", write_addr, 5'd1);
      check("t1_wdata", write_data, 32'hDEADBEEF);
      cycle();
      check("t1_rf", rf_dut[1], 32'hDEADBEEF);

      // 2: write to x0 is accepted and dropped
      drive(1'b1, 5'd0, 32'hCAFECAFE, 1'b0);
      cycle();
      check("t2_count", count, 3'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      cycle();
      check("t2_wen", reg_write_enable, 1'b0);
      check("t2_rf0", rf_dut[0], 32'd0);

      // 3: fill under stall, overflow attempt, ordered drain
      drive(1'b1, 5'd5, 32'h12345678, 1'b1); cycle();
      drive(1'b1, 5'd6, 32'd1, 1'b1);        cycle();
      drive(1'b1, 5'd7, 32'd2, 1'b1);        cycle();
      drive(1'b1, 5'd8, 32'd3, 1'b1);        cycle();
      check("t3_count", count, 3'd4);
      check("t3_ready", enq_ready, 1'b0);
      drive(1'b1, 5'd9, 32'd4, 1'b1);        cycle();
      check("t3_count_full", count, 3'd4);
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("t3_order", write_addr, 5'(5 + i));
      end
      cycle();

      // 4: youngest-match forwarding and same-register ordering
      lookup_addr1 = 5'd3;
      drive(1'b1, 5'd3, 32'h11, 1'b1); cycle();
      drive(1'b1, 5'd3, 32'h22, 1'b1); cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b1);
      #1;
      check("t4_hit", fwd_hit1, 1'b1);
      check("t4_data", fwd_data1, 32'h22);
      cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      repeat (4) cycle();
      check("t4_rf", rf_dut[3], 32'h22);

      // 5: reset mid-drain discards everything
      lookup_addr1 = 5'd10; lookup_addr2 = 5'd12;
      drive(1'b1, 5'd10, 32'hA, 1'b1); cycle();
      drive(1'b1, 5'd11, 32'hB, 1'b1); cycle();
      drive(1'b1, 5'd12, 32'hC, 1'b1); cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0);  cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      check("t5_count", count, 3'd0);
      check("t5_empty", empty, 1'b1);
      check("t5_wen", reg_write_enable, 1'b0);
      check("t5_hit1", fwd_hit1, 1'b0);
      check("t5_hit2", fwd_hit2, 1'b0);
      repeat (3) cycle();
      check("t5_rf12", rf_dut[12], 32'd0);

      // 6: simultaneous push/pop at two entries across a pointer wrap
      drive(1'b1, 5'd20, 32'h100, 1'b1); cycle();
      drive(1'b1, 5'd21, 32'h101, 1'b1); cycle();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 5'(22 + i), 32'h200 + 32'(i), 1'b0);
         cycle();
         check("t6_count", count, 3'd2);
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      repeat (4) cycle();

      // Randomized traffic with frequent address collisions
      for (int n = 0; n < 400; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         lookup_addr1 = 5'($urandom_range(0, 7));
         lookup_addr2 = 5'($urandom_range(0, 7));
         drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 9) < 3));
         cycle();
      end
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      repeat (6) cycle();
      for (int i = 0; i < 32; i++) check("rf_final", rf_dut[i], rf_m[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writer-side front end for the core's 32x32 register file: buffers register writebacks from the ALU and load paths, drains them one per cycle into the regfile write port (reg_write_enable / write_addr / write_data).
- Offers a forwarding lookup so decode can read values that are still pending.
- Sits between the writeback stage and regfile; the regfile read ports are untouched.

Parameters:
- XLEN, 32, data width of a register.
- AW, 5, register address width (32 architectural registers).
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- enq_valid  input  1  writeback request valid
- enq_ready  output  1  queue can accept; equals !full, registered-state only, no combinational dependence on stall
- enq_addr  input  AW  destination register
- enq_data  input  XLEN  value to write
- wb_stall  input  1  hold the drain; no pop this cycle
- reg_write_enable  output  1  registered; to regfile write enable
- write_addr  output  AW  registered; to regfile write address
- write_data  output  XLEN  registered; to regfile write data
- lookup_addr1, lookup_addr2  input  AW  decode source registers
- fwd_hit1, fwd_hit2  output  1  pending value exists for that address (combinational)
- fwd_data1, fwd_data2  output  XLEN  youngest pending value; 0 when no hit
- count  output  $clog2(DEPTH)+1  entries held (excludes the output stage)
- empty  output  1  count == 0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: count=0, read/write pointers=0, reg_write_enable=0, write_addr=0, write_data=0. Reset mid-operation discards all pending writes, including the output stage.
- Enqueue: occurs at a rising edge when enq_valid && enq_ready.
  - enq_addr==0: the handshake completes (accepted) but nothing is stored, since x0 is hardwired zero.
  - Otherwise the entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Drain: at each edge with !wb_stall && !empty, the head is popped into the output registers and reg_write_enable is set to 1.
  - Otherwise reg_write_enable <= 0; write_addr and write_data hold their previous values.
  - The output stage is a one-cycle pulse and is never held by wb_stall once loaded.
- Latency: an entry enqueued at edge N with an empty queue and no stall appears on the regfile port during cycle N+1. The regfile commits it at edge N+2.
- Simultaneous enqueue and pop:
  - Both happen; count is unchanged.
  - Full queue: enq_ready=0 even if a pop occurs that cycle.
  - Empty queue: the new entry is not bypassed; it drains on the following edge.
- Ordering: strictly FIFO. Two writes to the same register commit in arrival order.
- Forwarding search order: (a) youngest matching valid queue entry, (b) the output stage if reg_write_enable && write_addr matches, (c) miss.
  - lookup_addr==0 always misses, with data 0.
  - Entries enqueued in the current cycle are not visible until after the edge.
- count arithmetic: width $clog2(DEPTH)+1, so count==DEPTH is representable. full = (count==DEPTH).
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Assertions for verification:
  - Never enqueue while full.
  - count never exceeds DEPTH.
  - reg_write_enable is never asserted with write_addr==0.

Decomposition:
- Shared core package (riscv_pkg):
  - XLEN and AW constants.
  - reg_addr_t (logic [AW-1:0]) and xlen_t (logic [XLEN-1:0]) typedefs.
  - wb_entry_t packed struct {reg_addr_t addr; xlen_t data;}.
- Sub-module: regfile_write_queue_fwd, a combinational youngest-match search over the entry array, instantiated twice (one per lookup port).
- Storage and pointers stay in the top module.

Test Plan:
1. Reset, then enqueue addr=1, data=0xDEADBEEF with no stall → reg_write_enable=1, write_addr=1, write_data=0xDEADBEEF exactly one cycle later; after drain, regfile x1 reads 0xDEADBEEF.
2. Enqueue addr=0, data=0xCAFECAFE → enq_ready stays 1, count stays 0, reg_write_enable stays 0; regfile x0 reads 0.
3. Hold wb_stall=1 and enqueue 4 entries (x5=0x12345678, x6=1, x7=2, x8=3) → count=4, enq_ready=0. Attempt a fifth enqueue → ignored. Release stall → 4 consecutive pulses in order x5..x8.
4. With wb_stall=1, enqueue x3=0x11 then x3=0x22; set lookup_addr1=3 → fwd_hit1=1, fwd_data1=0x22. Release stall → writes commit as 0x11 then 0x22; regfile x3 ends at 0x22.
5. Fill to 3 entries and assert rst for one cycle mid-drain → next cycle count=0, empty=1, reg_write_enable=0, fwd_hit1/2=0; no further regfile writes occur.
6. With the queue at 2 entries, pulse enq and pop on the same edge → count stays 2 and ordering is preserved. Repeat across a pointer wrap (8 pushes) → data observed out equals data in.
